// File: rtl/axi_write_slave.sv
// AXI write-path slave slice: one INCR burst at a time into word memory, B tagged with the full interconnect ID.
// Latency: first W beat the cycle after AW; B_valid the cycle after the final beat; AW_ready one cycle after the B handshake.
// Backpressure: single burst in flight; AW held off until B completes; B holds until B_ready. Byte strobes under AXI_WRITE_SLAVE_WSTRB_EN.
module axi_write_slave #(
    parameter int ADDR_WIDTH            = 32,
    parameter int DATA_WIDTH            = 32,
    parameter int M                     = 2,
    parameter int NUM_OUTSTANDING_TRANS = 2,
    parameter int MEM_DEPTH             = 256,
    localparam int ID_WIDTH             = $clog2(M) + $clog2(NUM_OUTSTANDING_TRANS),
    localparam int MW                   = $clog2(MEM_DEPTH),
    localparam int STRB_W               = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  AW_valid,
    output logic                  AW_ready,
    input  logic [ADDR_WIDTH-1:0] AW_addr,
    input  logic [ID_WIDTH-1:0]   AW_id,
    input  logic [7:0]            AW_len,
    input  logic                  W_valid,
    output logic                  W_ready,
    input  logic [DATA_WIDTH-1:0] W_data,
    input  logic [STRB_W-1:0]     W_strb,
    input  logic                  W_last,
    output logic                  B_valid,
    input  logic                  B_ready,
    output logic [ID_WIDTH-1:0]   B_id,
    output logic [1:0]            B_resp,
    input  logic [MW-1:0]         dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int OFF = $clog2(STRB_W);   // byte-offset bits inside one word
    localparam int LOW = MW + OFF;         // first byte-address bit beyond the memory
    localparam int SW  = MW + 10;          // wide enough that index + len never wraps

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                state_q, state_d;
    logic                  aw_ready_q, aw_ready_d;
    logic                  w_ready_q, w_ready_d;
    logic                  b_valid_q, b_valid_d;
    logic [ID_WIDTH-1:0]   b_id_q, b_id_d;
    logic [1:0]            b_resp_q, b_resp_d;
    logic [MW:0]           idx_q, idx_d;
    logic [7:0]            len_q, len_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] addr_shift;
    logic [15:0]           slice_bits;
    logic [MW:0]           aw_idx;
    logic [SW-1:0]         end_sum;
    logic                  aw_err;
    logic [SW-1:0]         wr_sum;
    logic [MW-1:0]         wr_addr;
    logic                  aw_hs, w_hs, b_hs;
    logic                  at_len, beat_end, beat_bad, mem_we;

    assign addr_shift = AW_addr >> OFF;
    assign slice_bits = AW_addr[15:0] >> LOW;     // bits above the memory inside the 64 KiB slice
    assign aw_idx     = addr_shift[MW:0];
    assign end_sum    = SW'(aw_idx) + SW'(AW_len);
    assign aw_err     = (end_sum >= SW'(MEM_DEPTH)) || (slice_bits != '0);
    assign wr_sum     = SW'(idx_q) + SW'(cnt_q);
    assign wr_addr    = wr_sum[MW-1:0];

    assign aw_hs    = AW_valid & aw_ready_q;
    assign w_hs     = W_valid & w_ready_q;
    assign b_hs     = B_ready & b_valid_q;
    assign at_len   = (cnt_q == len_q);
    assign beat_end = at_len | W_last;
    assign beat_bad = at_len ^ W_last;            // early last, or missing last on the final beat
    assign mem_we   = (state_q == DATA) & w_hs & ~err_q;

    assign AW_ready = aw_ready_q;
    assign W_ready  = w_ready_q;
    assign B_valid  = b_valid_q;
    assign B_id     = b_id_q;
    assign B_resp   = b_resp_q;
    assign dbg_data = mem[dbg_addr];

    // State and registered handshake outputs; a reset mid-burst drops the burst with no B.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= 2'd0;
            idx_q      <= '0;
            len_q      <= '0;
            id_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_id_q     <= b_id_d;
            b_resp_q   <= b_resp_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state and next-output logic for the AW -> W -> B sequence.
    always_comb begin
        state_d    = state_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        b_id_d     = b_id_q;
        b_resp_d   = b_resp_q;
        idx_d      = idx_q;
        len_d      = len_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                aw_ready_d = 1'b1;
                if (aw_hs) begin
                    idx_d      = aw_idx;
                    len_d      = AW_len;
                    id_d       = AW_id;
                    cnt_d      = '0;
                    err_d      = aw_err;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if (beat_end) begin
                        err_d     = err_q | beat_bad;
                        w_ready_d = 1'b0;
                        b_valid_d = 1'b1;
                        b_id_d    = id_q;
                        b_resp_d  = (err_q | beat_bad) ? 2'd2 : 2'd0;
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AXI_WRITE_SLAVE_WSTRB_EN
    // Beat write into word memory, only strobed bytes; no reset on contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (W_strb[k]) mem[wr_addr][8*k +: 8] <= W_data[8*k +: 8];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{addr_shift[ADDR_WIDTH-1:MW+1], wr_sum[SW-1:MW]};
`else
    // Beat write into word memory, full word; no reset on contents.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr] <= W_data;
    end

    logic unused_bits;
    assign unused_bits = ^{addr_shift[ADDR_WIDTH-1:MW+1], wr_sum[SW-1:MW], W_strb};
`endif

endmodule

// File: tb/tb_axi_write_slave.sv
// Bench for axi_write_slave: directed bursts against a word-array memory model and expected-B record.
// A negedge compare process checks dbg_data and B outputs every cycle; literal peeks pin the model.
// Ends with a single summary line.
module tb_axi_write_slave;

    localparam int DEPTH = 256;
    localparam int IDW   = 2;

`ifdef AXI_WRITE_SLAVE_WSTRB_EN
    localparam logic [31:0] STRB_WANT = 32'hFF00FF00;
    localparam logic [31:0] NOOP_WANT = 32'hFF00FF00;
`else
    localparam logic [31:0] STRB_WANT = 32'h00000000;
    localparam logic [31:0] NOOP_WANT = 32'h12345678;
`endif

    logic           clk = 1'b0;
    logic           clr;
    logic           AW_valid, AW_ready;
    logic [31:0]    AW_addr;
    logic [IDW-1:0] AW_id;
    logic [7:0]     AW_len;
    logic           W_valid, W_ready;
    logic [31:0]    W_data;
    logic [3:0]     W_strb;
    logic           W_last;
    logic           B_valid, B_ready;
    logic [IDW-1:0] B_id;
    logic [1:0]     B_resp;
    logic [7:0]     dbg_addr;
    logic [31:0]    dbg_data;

    axi_write_slave dut (
        .clk(clk), .clr(clr),
        .AW_valid(AW_valid), .AW_ready(AW_ready), .AW_addr(AW_addr), .AW_id(AW_id), .AW_len(AW_len),
        .W_valid(W_valid), .W_ready(W_ready), .W_data(W_data), .W_strb(W_strb), .W_last(W_last),
        .B_valid(B_valid), .B_ready(B_ready), .B_id(B_id), .B_resp(B_resp),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    logic [31:0]    mdl_mem   [DEPTH];
    bit             mdl_known [DEPTH];
    bit             exp_b = 1'b0;
    logic [IDW-1:0] exp_id = '0;
    logic [1:0]     exp_resp = 2'd0;
    int             n_checks = 0;
    int             n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, req);
    endtask

    task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] s);
`ifdef AXI_WRITE_SLAVE_WSTRB_EN
        for (int k = 0; k < 4; k++) if (s[k]) mdl_mem[a][8*k +: 8] = d[8*k +: 8];
        if (s == 4'hF) mdl_known[a] = 1'b1;
`else
        mdl_mem[a]   = d;
        mdl_known[a] = 1'b1;
`endif
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!clr) begin
            check("rst_aw_ready", 32'(AW_ready), 0);
            check("rst_w_ready", 32'(W_ready), 0);
            check("rst_b_valid", 32'(B_valid), 0);
            check("rst_b_id", 32'(B_id), 0);
            check("rst_b_resp", 32'(B_resp), 0);
        end else begin
            if (mdl_known[dbg_addr]) check("dbg_data", dbg_data, mdl_mem[dbg_addr]);
            if (B_valid) begin
                check("b_expected", 32'(exp_b), 1);
                if (exp_b) begin
                    check("b_id", 32'(B_id), 32'(exp_id));
                    check("b_resp", 32'(B_resp), 32'(exp_resp));
                end
            end
        end
    end

    // Starts and ends just after a rising edge.
    task automatic burst(input logic [31:0] addr, input logic [7:0] len, input logic [IDW-1:0] id,
                         input int nbeats, input logic [31:0] dat0, input logic [3:0] strb,
                         input bit last_on, input int hold_b,
                         output logic [1:0] resp_o, output logic [IDW-1:0] id_o);
        int idx, sent, t;
        bit err, bad, lastflag;
        idx      = int'((addr >> 2) & 32'h1FF);
        err      = ((idx + int'(len)) >= DEPTH) || (addr[15:10] != 6'd0);
        sent     = (nbeats < int'(len) + 1) ? nbeats : int'(len) + 1;
        lastflag = last_on && (sent == nbeats);
        bad      = err || !(lastflag && (sent == int'(len) + 1));
        resp_o   = 2'd3;
        id_o     = '0;
        AW_valid = 1'b1; AW_addr = addr; AW_id = id; AW_len = len;
        t = 0;
        do begin @(negedge clk); t++; end while (!AW_ready && t < 50);
        if (!AW_ready) begin check("aw_timeout", 32'(AW_ready), 1); AW_valid = 1'b0; return; end
        @(posedge clk); #1;
        AW_valid = 1'b0;
        dbg_addr = idx[7:0];
        for (int b = 0; b < sent; b++) begin
            W_valid = 1'b1; W_data = dat0 + 32'(b); W_strb = strb;
            W_last  = last_on && (b == nbeats - 1);
            t = 0;
            do begin
                @(negedge clk); t++;
                check("aw_ready_busy", 32'(AW_ready), 0);
            end while (!W_ready && t < 50);
            if (!W_ready) begin check("w_timeout", 32'(W_ready), 1); W_valid = 1'b0; return; end
            @(posedge clk); #1;
            if (!err) model_write(idx + b, dat0 + 32'(b), strb);
        end
        W_valid = 1'b0; W_last = 1'b0;
        exp_b = 1'b1; exp_id = id; exp_resp = bad ? 2'd2 : 2'd0;
        @(negedge clk);
        check("b_latency", 32'(B_valid), 1);
        check("w_ready_end", 32'(W_ready), 0);
        for (int h = 0; h < hold_b; h++) begin
            @(negedge clk);
            check("b_hold", 32'(B_valid), 1);
            check("aw_ready_hold", 32'(AW_ready), 0);
            check("w_ready_hold", 32'(W_ready), 0);
        end
        @(posedge clk); #1;
        B_ready = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!B_valid && t < 50);
        if (!B_valid) begin check("b_timeout", 32'(B_valid), 1); B_ready = 1'b0; return; end
        resp_o = B_resp; id_o = B_id;
        @(posedge clk); #1;
        B_ready = 1'b0; exp_b = 1'b0;
        @(negedge clk);
        check("b_drop", 32'(B_valid), 0);
        check("aw_ready_back", 32'(AW_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic peek(input string nm, input int a, input logic [31:0] want);
        dbg_addr = a[7:0];
        @(negedge clk);
        check(nm, dbg_data, want);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]     r;
        logic [IDW-1:0] i;
        clr = 1'b0; AW_valid = 1'b0; AW_addr = '0; AW_id = '0; AW_len = '0;
        W_valid = 1'b0; W_data = '0; W_strb = '0; W_last = 1'b0; B_ready = 1'b0; dbg_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_aw_ready", 32'(AW_ready), 0);
        @(posedge clk); #1; clr = 1'b1;
        @(negedge clk); check("aw_ready_pre_edge", 32'(AW_ready), 0);
        @(negedge clk); check("aw_ready_first_edge", 32'(AW_ready), 1);
        @(posedge clk); #1;

        // Single beat to word 4.
        burst(32'h10, 8'd0, 2'd3, 1, 32'hDEADBEEF, 4'hF, 1'b1, 0, r, i);
        check("t1_bid", 32'(i), 3);
        check("t1_bresp", 32'(r), 0);
        peek("t1_mem4", 4, 32'hDEADBEEF);

        // Four beats, B held off for five cycles.
        burst(32'h0, 8'd3, 2'd1, 4, 32'd1, 4'hF, 1'b1, 5, r, i);
        check("t2_bid", 32'(i), 1);
        check("t2_bresp", 32'(r), 0);
        for (int a = 0; a < 4; a++) peek("t2_mem", a, 32'(a + 1));

        // Out of range: preload word 255, then a burst running past the end.
        burst(32'h3FC, 8'd0, 2'd2, 1, 32'hA5A50255, 4'hF, 1'b1, 0, r, i);
        check("t3_pre_resp", 32'(r), 0);
        burst(32'h3FC, 8'd1, 2'd2, 2, 32'h1111, 4'hF, 1'b1, 0, r, i);
        check("t3_bresp", 32'(r), 2);
        peek("t3_mem255", 255, 32'hA5A50255);
        burst(32'h3F8, 8'd1, 2'd0, 2, 32'h2220, 4'hF, 1'b1, 0, r, i);
        check("t3_edge_ok", 32'(r), 0);
        peek("t3_mem254", 254, 32'h2220);
        burst(32'h8010, 8'd0, 2'd1, 1, 32'h3330, 4'hF, 1'b1, 0, r, i);
        check("t3_slice_err", 32'(r), 2);
        burst(32'h10010, 8'd0, 2'd1, 1, 32'h4440, 4'hF, 1'b1, 0, r, i);
        check("t3_above_slice_ok", 32'(r), 0);
        peek("t3_mem4", 4, 32'h4440);

        // Early last on beat 2 of 4.
        burst(32'h40, 8'd3, 2'd1, 4, 32'h100, 4'hF, 1'b1, 0, r, i);
        burst(32'h40, 8'd3, 2'd2, 2, 32'h200, 4'hF, 1'b1, 0, r, i);
        check("t4_bresp", 32'(r), 2);
        check("t4_bid", 32'(i), 2);
        peek("t4_mem16", 16, 32'h200);
        peek("t4_mem17", 17, 32'h201);
        peek("t4_mem18", 18, 32'h102);
        peek("t4_mem19", 19, 32'h103);

        // Final beat without W_last.
        burst(32'h80, 8'd1, 2'd0, 2, 32'h300, 4'hF, 1'b0, 0, r, i);
        check("t5_bresp", 32'(r), 2);
        peek("t5_mem33", 33, 32'h301);

        // Byte strobes.
        burst(32'h0, 8'd0, 2'd0, 1, 32'hFFFFFFFF, 4'hF, 1'b1, 0, r, i);
        burst(32'h0, 8'd0, 2'd0, 1, 32'h00000000, 4'b0101, 1'b1, 0, r, i);
        check("t6_bresp", 32'(r), 0);
        peek("t6_strb", 0, STRB_WANT);
        burst(32'h0, 8'd0, 2'd0, 1, 32'h12345678, 4'b0000, 1'b1, 0, r, i);
        check("t6_noop_bresp", 32'(r), 0);
        peek("t6_noop", 0, NOOP_WANT);

        // Reset after the first beat of a four-beat burst.
        AW_valid = 1'b1; AW_addr = 32'hC0; AW_id = 2'd2; AW_len = 8'd3;
        @(negedge clk); check("t7_aw_ready", 32'(AW_ready), 1);
        @(posedge clk); #1;
        AW_valid = 1'b0; W_valid = 1'b1; W_data = 32'h77; W_strb = 4'hF; W_last = 1'b0;
        dbg_addr = 8'd48;
        @(negedge clk); check("t7_w_ready", 32'(W_ready), 1);
        @(posedge clk); #1;
        model_write(48, 32'h77, 4'hF);
        W_valid = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1; clr = 1'b1;
        @(negedge clk); check("t7_aw_pre_edge", 32'(AW_ready), 0);
        @(negedge clk); check("t7_aw_first_edge", 32'(AW_ready), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); check("t7_no_b", 32'(B_valid), 0);
        end
        @(posedge clk); #1;
        peek("t7_mem48", 48, 32'h77);
        burst(32'hC4, 8'd0, 2'd1, 1, 32'h88, 4'hF, 1'b1, 0, r, i);
        check("t7_recover_bresp", 32'(r), 0);
        peek("t7_mem49", 49, 32'h88);

        // Sweep every word so the compare process sees all known contents.
        for (int a = 0; a < DEPTH; a++) begin
            dbg_addr = a[7:0];
            @(negedge clk);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
